// File: rtl/fu_cfg_pkg.sv
// Shared definitions for the FU configuration loader: header layout,
// packet FSM states and field-packing helpers.
package fu_cfg_pkg;

  localparam logic [7:0] CFG_MAGIC     = 8'hC5;
  localparam int         HDR_MAGIC_LSB = 24;
  localparam int         HDR_COUNT_LSB = 8;
  localparam int         HDR_START_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    COMMIT = 2'd2
  } cfg_state_e;

  function automatic int fields_per_word(input int cfg_w);
    return 32 / cfg_w;
  endfunction

  localparam int FIELDS_PER_WORD = fields_per_word(2);

endpackage

// File: rtl/fu_cfg_loader_if.sv
// Valid/ready configuration word stream feeding the loader.
interface fu_cfg_loader_if #(
  parameter int SIZE = 32
);
  logic [SIZE-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/fu_cfg_unpack.sv
// Maps one data word onto per-cell write enables/data, starting at the
// current field pointer and limited by the fields still owed by the packet.
module fu_cfg_unpack
  import fu_cfg_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int NUM_CELLS = 16,
  parameter int CFG_W     = 2
) (
  input  logic [SIZE-1:0]            word,
  input  logic [7:0]                 ptr,
  input  logic [7:0]                 rem,
  output logic [NUM_CELLS-1:0]       wr_en,
  output logic [NUM_CELLS*CFG_W-1:0] wr_data
);

  localparam int FPW = fields_per_word(CFG_W);

  logic [8:0]      off;
  logic [8:0]      lim;
  logic [SIZE-1:0] field_word;

  always_comb begin
    wr_en      = '0;
    wr_data    = '0;
    off        = '0;
    field_word = '0;
    lim        = ({1'b0, rem} < 9'(FPW)) ? {1'b0, rem} : 9'(FPW);
    // Cell i takes field (i - ptr) when that field lies inside this word and the packet
    for (int i = 0; i < NUM_CELLS; i++) begin
      off        = 9'(i) - {1'b0, ptr};
      field_word = word >> (32'(off) * 32'(CFG_W));
      if ((9'(i) >= {1'b0, ptr}) && (off < lim)) begin
        wr_en[i]                   = 1'b1;
        wr_data[i*CFG_W +: CFG_W]  = field_word[CFG_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fu_cfg_loader.sv
// Configuration loader: header + data words fill a shadow store that is
// committed to config_sig in one cycle, so cells never see partial updates.
module fu_cfg_loader
  import fu_cfg_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int NUM_CELLS = 16,
  parameter int CFG_W     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fu_cfg_loader_if.slave             in_if,
  output logic [NUM_CELLS*CFG_W-1:0] config_sig,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic                       busy
);

  localparam int FPW = fields_per_word(CFG_W);
  localparam int W   = NUM_CELLS * CFG_W;

  cfg_state_e state, state_nxt;
  logic [7:0] ptr, ptr_nxt;
  logic [7:0] rem, rem_nxt;
  logic [W-1:0] shadow, shadow_nxt;
  logic in_ready_q;
  logic err_set, err_p0;
  logic data_we;
  logic xfer;

  logic [7:0] hdr_magic, hdr_count, hdr_start;
  logic [8:0] hdr_end;
  logic       hdr_ok;

  logic [NUM_CELLS-1:0] wr_en;
  logic [W-1:0]         wr_data;

  assign in_if.in_ready = in_ready_q;
  assign xfer           = in_if.in_valid && in_ready_q;

  assign hdr_magic = in_if.in_data[HDR_MAGIC_LSB +: 8];
  assign hdr_count = in_if.in_data[HDR_COUNT_LSB +: 8];
  assign hdr_start = in_if.in_data[HDR_START_LSB +: 8];
  // Nine-bit sum so start+count cannot wrap past the cell range
  assign hdr_end   = {1'b0, hdr_start} + {1'b0, hdr_count};
  assign hdr_ok    = (hdr_magic == CFG_MAGIC) && (hdr_count != 8'd0) &&
                     (hdr_end <= 9'(NUM_CELLS));

  fu_cfg_unpack #(
    .SIZE      (SIZE),
    .NUM_CELLS (NUM_CELLS),
    .CFG_W     (CFG_W)
  ) u_unpack (
    .word    (in_if.in_data),
    .ptr     (ptr),
    .rem     (rem),
    .wr_en   (wr_en),
    .wr_data (wr_data)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    rem_nxt   = rem;
    err_set   = 1'b0;
    data_we   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            state_nxt = DATA;
            ptr_nxt   = hdr_start;
            rem_nxt   = hdr_count;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          data_we = 1'b1;
          if ({1'b0, rem} <= 9'(FPW)) begin
            rem_nxt   = 8'd0;
            state_nxt = COMMIT;
          end else begin
            rem_nxt = rem - 8'(FPW);
            ptr_nxt = ptr + 8'(FPW);
          end
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_nxt = shadow;
    if (data_we) begin
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (wr_en[i]) shadow_nxt[i*CFG_W +: CFG_W] = wr_data[i*CFG_W +: CFG_W];
      end
    end
  end

  // Stage boundary: FSM, shadow store and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      rem        <= '0;
      shadow     <= '0;
      config_sig <= '0;
      in_ready_q <= 1'b1;
      busy       <= 1'b0;
      cfg_done   <= 1'b0;
      err_p0     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      rem        <= rem_nxt;
      shadow     <= shadow_nxt;
      in_ready_q <= (state_nxt != COMMIT);
      busy       <= (state_nxt != IDLE);
      cfg_done   <= (state == COMMIT);
      if (state == COMMIT) config_sig <= shadow;
      err_p0     <= err_set;
      cfg_err    <= err_p0;
    end
  end

endmodule
